// File: rtl/mem_access_if.sv
// rtl/mem_access_if.sv - data-memory request/response bus between mem_access and the memory
// Ports (master = mem_access side):
//   dmem_req/dmem_we/dmem_addr/dmem_wdata/dmem_strb : request, held stable until dmem_ready
//   dmem_ready                                      : request accepted this cycle
//   dmem_rvalid/dmem_rdata                          : read response
interface mem_access_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [63:0] dmem_addr;
    logic [63:0] dmem_wdata;
    logic [7:0]  dmem_strb;
    logic        dmem_ready;
    logic        dmem_rvalid;
    logic [63:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_strb,
        input  dmem_ready, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_strb,
        output dmem_ready, dmem_rvalid, dmem_rdata
    );
endinterface

// File: rtl/mem_access.sv
// rtl/mem_access.sv - pipeline memory-access stage: load/store sequencing, load extension, writeback
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   ex_*, mem_*, addr_mem_*, data_mem_wr, strb_mem_wr, load_code, alu_result, rd_* : execute-side inputs
//   dmem            : data-memory bus (mem_access_if.master)
//   wb_*            : registered writeback pulse and payload
//   stall_req       : combinational upstream freeze
//   bus_err         : timeout pulse
// Optional feature: define MEM_TIMEOUT_EN to abort REQ/RESP after 255 cycles with bus_err.
module mem_access (
    input  logic         clk,
    input  logic         rst,
    input  logic         ex_valid,
    input  logic         mem_rd_en,
    input  logic         mem_wr_en,
    input  logic [63:0]  addr_mem_rd,
    input  logic [63:0]  addr_mem_wr,
    input  logic [63:0]  data_mem_wr,
    input  logic [7:0]   strb_mem_wr,
    input  logic [2:0]   load_code,
    input  logic [63:0]  alu_result,
    input  logic [4:0]   rd_addr,
    input  logic         rd_wr_en,
    input  logic         mem_except,
    mem_access_if.master dmem,
    output logic         wb_valid,
    output logic [63:0]  wb_data,
    output logic [4:0]   wb_rd_addr,
    output logic         wb_wr_en,
    output logic         wb_except,
    output logic         stall_req,
    output logic         bus_err
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        lat_store;
    logic [2:0]  lat_code;
    logic [2:0]  lat_off;
    logic [4:0]  lat_rd;
    logic        lat_wen;

    logic        mem_op;
    logic        timeout;
    logic [63:0] rdata_shift;
    logic [63:0] load_data;

    assign mem_op    = ex_valid & ~mem_except & (mem_rd_en | mem_wr_en);
    assign stall_req = (state != IDLE) | mem_op;

`ifdef MEM_TIMEOUT_EN
    logic [7:0] tmo_cnt;

    // Fires on the edge that takes the count to 255, so bus_err becomes
    // visible 255 cycles after the first REQ cycle. A completing handshake
    // in the same cycle wins over the timeout.
    assign timeout = (tmo_cnt == 8'd254) &
                     (((state == REQ)  & ~dmem.dmem_ready) |
                      ((state == RESP) & ~dmem.dmem_rvalid));

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt <= 8'd0;
            bus_err <= 1'b0;
        end else begin
            bus_err <= timeout;
            // Held at zero in IDLE, so it is cleared on entry to REQ.
            if (state == IDLE) begin
                tmo_cnt <= 8'd0;
            end else if (tmo_cnt != 8'hFF) begin
                tmo_cnt <= tmo_cnt + 8'd1;
            end
        end
    end
`else
    assign timeout = 1'b0;
    assign bus_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (mem_op) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (dmem.dmem_ready) begin
                    state_next = lat_store ? IDLE : RESP;
                end else if (timeout) begin
                    state_next = IDLE;
                end
            end
            RESP: begin
                if (dmem.dmem_rvalid || timeout) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Align the addressed byte lane to bit 0, then extend to the load width.
    assign rdata_shift = dmem.dmem_rdata >> {lat_off, 3'b000};

    always_comb begin
        load_data = rdata_shift;
        case (lat_code)
            3'b001:  load_data = {{56{rdata_shift[7]}},  rdata_shift[7:0]};
            3'b010:  load_data = {{48{rdata_shift[15]}}, rdata_shift[15:0]};
            3'b011:  load_data = {{32{rdata_shift[31]}}, rdata_shift[31:0]};
            3'b101:  load_data = {56'd0, rdata_shift[7:0]};
            3'b110:  load_data = {48'd0, rdata_shift[15:0]};
            3'b111:  load_data = {32'd0, rdata_shift[31:0]};
            default: load_data = rdata_shift;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dmem.dmem_req   <= 1'b0;
            dmem.dmem_we    <= 1'b0;
            dmem.dmem_addr  <= 64'd0;
            dmem.dmem_wdata <= 64'd0;
            dmem.dmem_strb  <= 8'd0;
            wb_valid        <= 1'b0;
            wb_data         <= 64'd0;
            wb_rd_addr      <= 5'd0;
            wb_wr_en        <= 1'b0;
            wb_except       <= 1'b0;
            lat_store       <= 1'b0;
            lat_code        <= 3'd0;
            lat_off         <= 3'd0;
            lat_rd          <= 5'd0;
            lat_wen         <= 1'b0;
        end else begin
            wb_valid  <= 1'b0;
            wb_except <= 1'b0;
            case (state)
                IDLE: begin
                    if (ex_valid) begin
                        if (mem_except) begin
                            wb_valid   <= 1'b1;
                            wb_wr_en   <= 1'b0;
                            wb_except  <= 1'b1;
                            wb_rd_addr <= rd_addr;
                        end else if (mem_rd_en | mem_wr_en) begin
                            dmem.dmem_req <= 1'b1;
                            lat_store     <= mem_wr_en;
                            lat_code      <= load_code;
                            lat_rd        <= rd_addr;
                            lat_wen       <= rd_wr_en;
                            // A store wins when both enables are set.
                            if (mem_wr_en) begin
                                dmem.dmem_we    <= 1'b1;
                                dmem.dmem_addr  <= addr_mem_wr;
                                dmem.dmem_wdata <= data_mem_wr << {addr_mem_wr[2:0], 3'b000};
                                dmem.dmem_strb  <= strb_mem_wr << addr_mem_wr[2:0];
                                lat_off         <= addr_mem_wr[2:0];
                            end else begin
                                dmem.dmem_we    <= 1'b0;
                                dmem.dmem_addr  <= addr_mem_rd;
                                dmem.dmem_wdata <= 64'd0;
                                dmem.dmem_strb  <= 8'd0;
                                lat_off         <= addr_mem_rd[2:0];
                            end
                        end else begin
                            wb_valid   <= 1'b1;
                            wb_data    <= alu_result;
                            wb_rd_addr <= rd_addr;
                            wb_wr_en   <= rd_wr_en;
                        end
                    end
                end
                REQ: begin
                    if (dmem.dmem_ready) begin
                        dmem.dmem_req <= 1'b0;
                        if (lat_store) begin
                            wb_valid   <= 1'b1;
                            wb_wr_en   <= 1'b0;
                            wb_rd_addr <= lat_rd;
                        end
                    end else if (timeout) begin
                        dmem.dmem_req <= 1'b0;
                        wb_valid      <= 1'b1;
                        wb_wr_en      <= 1'b0;
                        wb_except     <= 1'b1;
                        wb_rd_addr    <= lat_rd;
                    end
                end
                RESP: begin
                    if (dmem.dmem_rvalid) begin
                        wb_valid   <= 1'b1;
                        wb_data    <= load_data;
                        wb_wr_en   <= lat_wen;
                        wb_rd_addr <= lat_rd;
                    end else if (timeout) begin
                        wb_valid   <= 1'b1;
                        wb_wr_en   <= 1'b0;
                        wb_except  <= 1'b1;
                        wb_rd_addr <= lat_rd;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - self-checking bench for mem_access
module tb_mem_access;
    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, mem_rd_en, mem_wr_en;
    logic [63:0] addr_mem_rd, addr_mem_wr, data_mem_wr;
    logic [7:0]  strb_mem_wr;
    logic [2:0]  load_code;
    logic [63:0] alu_result;
    logic [4:0]  rd_addr;
    logic        rd_wr_en, mem_except;
    logic        wb_valid, wb_wr_en, wb_except, stall_req, bus_err;
    logic [63:0] wb_data;
    logic [4:0]  wb_rd_addr;

    always #5 clk = ~clk;

    mem_access_if dmem_if ();

    mem_access dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
        .addr_mem_rd(addr_mem_rd), .addr_mem_wr(addr_mem_wr), .data_mem_wr(data_mem_wr),
        .strb_mem_wr(strb_mem_wr), .load_code(load_code), .alu_result(alu_result),
        .rd_addr(rd_addr), .rd_wr_en(rd_wr_en), .mem_except(mem_except), .dmem(dmem_if),
        .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd_addr(wb_rd_addr), .wb_wr_en(wb_wr_en),
        .wb_except(wb_except), .stall_req(stall_req), .bus_err(bus_err)
    );

    localparam int K_PASS  = 0;
    localparam int K_LOAD  = 1;
    localparam int K_STORE = 2;
    localparam int K_EXC   = 3;

    typedef struct {
        int          kind;
        logic [2:0]  code;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  strb;
        logic [63:0] rdata;
        logic [63:0] alu;
        logic [4:0]  rd;
        logic        wen;
        logic        both;
        int          rdy_dly;
        int          rv_dly;
        logic [63:0] exp_data;
        logic [63:0] exp_wdata;
        logic [7:0]  exp_strb;
    } vec_t;

    int n_pass  = 0;
    int n_total = 0;
    int hit;
    int nbe;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: byte-lane view of load extraction and store placement.
    function automatic logic [63:0] model_load(input logic [2:0] code, input int off, input logic [63:0] rdata);
        int          nbytes;
        bit          sgn;
        logic [63:0] v, mask;
        case (code)
            3'd1: begin nbytes = 1; sgn = 1; end
            3'd2: begin nbytes = 2; sgn = 1; end
            3'd3: begin nbytes = 4; sgn = 1; end
            3'd5: begin nbytes = 1; sgn = 0; end
            3'd6: begin nbytes = 2; sgn = 0; end
            3'd7: begin nbytes = 4; sgn = 0; end
            default: begin nbytes = 8; sgn = 0; end
        endcase
        v = 64'd0;
        for (int b = 0; b < 8; b++)
            if (b + off < 8) v[8*b +: 8] = rdata[8*(b+off) +: 8];
        mask = (nbytes == 8) ? {64{1'b1}} : ((64'd1 << (8*nbytes)) - 64'd1);
        v = v & mask;
        if (sgn && v[8*nbytes-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [63:0] model_wdata(input logic [63:0] d, input int off);
        logic [63:0] r = 64'd0;
        for (int b = 0; b < 8; b++)
            if (b >= off) r[8*b +: 8] = d[8*(b-off) +: 8];
        return r;
    endfunction

    function automatic logic [7:0] model_strb(input logic [7:0] s, input int off);
        logic [7:0] r = 8'd0;
        for (int b = 0; b < 8; b++)
            if (b >= off) r[b] = s[b-off];
        return r;
    endfunction

    function automatic vec_t mk(input int kind, input logic [2:0] code, input logic [63:0] addr,
                                input logic [63:0] wdata, input logic [7:0] strb, input logic [63:0] rdata,
                                input logic [63:0] alu, input logic [4:0] rd, input logic wen, input logic both,
                                input int rdy, input int rv, input logic [63:0] exp_data,
                                input logic [63:0] exp_wdata, input logic [7:0] exp_strb);
        vec_t v;
        v.kind = kind; v.code = code; v.addr = addr; v.wdata = wdata; v.strb = strb;
        v.rdata = rdata; v.alu = alu; v.rd = rd; v.wen = wen; v.both = both;
        v.rdy_dly = rdy; v.rv_dly = rv; v.exp_data = exp_data;
        v.exp_wdata = exp_wdata; v.exp_strb = exp_strb;
        return v;
    endfunction

    task automatic clear_ex();
        ex_valid    = 1'b0;
        mem_rd_en   = 1'b0;
        mem_wr_en   = 1'b0;
        mem_except  = 1'b0;
        // Scramble the rest so that anything not latched shows up.
        addr_mem_rd = {$urandom, $urandom};
        addr_mem_wr = {$urandom, $urandom};
        data_mem_wr = {$urandom, $urandom};
        strb_mem_wr = 8'($urandom);
        load_code   = 3'($urandom);
        alu_result  = {$urandom, $urandom};
        rd_addr     = 5'($urandom);
        rd_wr_en    = 1'($urandom);
    endtask

    task automatic apply(input vec_t v, input string tag);
        bit is_mem;
        is_mem      = (v.kind == K_LOAD) || (v.kind == K_STORE);
        ex_valid    = 1'b1;
        mem_rd_en   = (v.kind == K_LOAD) || (v.kind == K_EXC) || ((v.kind == K_STORE) && v.both);
        mem_wr_en   = (v.kind == K_STORE);
        mem_except  = (v.kind == K_EXC);
        addr_mem_rd = v.addr;
        addr_mem_wr = v.addr;
        data_mem_wr = v.wdata;
        strb_mem_wr = v.strb;
        load_code   = v.code;
        alu_result  = v.alu;
        rd_addr     = v.rd;
        rd_wr_en    = v.wen;
        #1;
        chk({tag, ".stall_accept"}, stall_req, is_mem);
        tick();
        clear_ex();
        if (!is_mem) begin
            chk({tag, ".no_req"}, dmem_if.dmem_req, 0);
            chk({tag, ".wb_valid"}, wb_valid, 1);
            chk({tag, ".wb_except"}, wb_except, v.kind == K_EXC);
            chk({tag, ".wb_wr_en"}, wb_wr_en, (v.kind == K_PASS) ? v.wen : 1'b0);
            chk({tag, ".stall_wb"}, stall_req, 0);
            if (v.kind == K_PASS) begin
                chk({tag, ".wb_data"}, wb_data, v.exp_data);
                chk({tag, ".wb_rd"}, wb_rd_addr, v.rd);
            end
        end else begin
            for (int i = 0; i <= v.rdy_dly; i++) begin
                if (i == v.rdy_dly) begin
                    dmem_if.dmem_ready = 1'b1;
                    // A response beat alongside acceptance must be ignored.
                    if (v.kind == K_LOAD) begin
                        dmem_if.dmem_rvalid = 1'b1;
                        dmem_if.dmem_rdata  = ~v.rdata;
                    end
                end
                chk({tag, ".req"}, dmem_if.dmem_req, 1);
                chk({tag, ".we"}, dmem_if.dmem_we, v.kind == K_STORE);
                chk({tag, ".addr"}, dmem_if.dmem_addr, v.addr);
                chk({tag, ".strb"}, dmem_if.dmem_strb, (v.kind == K_STORE) ? v.exp_strb : 8'd0);
                if (v.kind == K_STORE) chk({tag, ".wdata"}, dmem_if.dmem_wdata, v.exp_wdata);
                chk({tag, ".stall_req"}, stall_req, 1);
                chk({tag, ".no_wb_req"}, wb_valid, 0);
                tick();
            end
            dmem_if.dmem_ready  = 1'b0;
            dmem_if.dmem_rvalid = 1'b0;
            if (v.kind == K_STORE) begin
                chk({tag, ".st_wb_valid"}, wb_valid, 1);
                chk({tag, ".st_wb_wr_en"}, wb_wr_en, 0);
                chk({tag, ".st_wb_except"}, wb_except, 0);
                chk({tag, ".st_req_drop"}, dmem_if.dmem_req, 0);
                chk({tag, ".st_stall"}, stall_req, 0);
            end else begin
                chk({tag, ".resp_req_low"}, dmem_if.dmem_req, 0);
                chk({tag, ".early_rvalid_ignored"}, wb_valid, 0);
                chk({tag, ".resp_stall"}, stall_req, 1);
                for (int i = 0; i < v.rv_dly; i++) begin
                    dmem_if.dmem_rdata = {$urandom, $urandom};
                    tick();
                    chk({tag, ".resp_wait"}, wb_valid, 0);
                    chk({tag, ".resp_wait_req"}, dmem_if.dmem_req, 0);
                end
                dmem_if.dmem_rvalid = 1'b1;
                dmem_if.dmem_rdata  = v.rdata;
                tick();
                dmem_if.dmem_rvalid = 1'b0;
                dmem_if.dmem_rdata  = {$urandom, $urandom};
                chk({tag, ".ld_wb_valid"}, wb_valid, 1);
                chk({tag, ".ld_wb_data"}, wb_data, v.exp_data);
                chk({tag, ".ld_wb_wr_en"}, wb_wr_en, v.wen);
                chk({tag, ".ld_wb_rd"}, wb_rd_addr, v.rd);
                chk({tag, ".ld_wb_except"}, wb_except, 0);
                chk({tag, ".ld_stall"}, stall_req, 0);
            end
        end
        tick();
        chk({tag, ".wb_pulse"}, wb_valid, 0);
        chk({tag, ".except_pulse"}, wb_except, 0);
        if (v.kind == K_PASS || v.kind == K_LOAD) chk({tag, ".wb_data_hold"}, wb_data, v.exp_data);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[$];
        vec_t v;
        int   off;

        tbl.push_back(mk(K_LOAD, 3'd1, 64'h1000, 0, 0, 64'h0000_0000_0000_00F0, 0, 5'd1, 1, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFF0, 0, 0));
        tbl.push_back(mk(K_LOAD, 3'd7, 64'h1008, 0, 0, 64'hFFFF_FFFF_8000_0000, 0, 5'd2, 1, 0, 1, 2, 64'h0000_0000_8000_0000, 0, 0));
        tbl.push_back(mk(K_LOAD, 3'd6, 64'h1010, 0, 0, 64'h0000_0000_0000_8001, 0, 5'd3, 1, 0, 0, 1, 64'h0000_0000_0000_8001, 0, 0));
        tbl.push_back(mk(K_LOAD, 3'd2, 64'h1002, 0, 0, 64'h0000_0000_8001_0000, 0, 5'd4, 1, 0, 2, 0, 64'hFFFF_FFFF_FFFF_8001, 0, 0));
        tbl.push_back(mk(K_LOAD, 3'd3, 64'h1004, 0, 0, 64'h8765_4321_0000_0000, 0, 5'd5, 0, 0, 0, 0, 64'hFFFF_FFFF_8765_4321, 0, 0));
        tbl.push_back(mk(K_LOAD, 3'd5, 64'h1007, 0, 0, 64'hA500_0000_0000_0000, 0, 5'd6, 1, 0, 1, 1, 64'h0000_0000_0000_00A5, 0, 0));
        tbl.push_back(mk(K_LOAD, 3'd4, 64'h1000, 0, 0, 64'h8123_4567_89AB_CDEF, 0, 5'd7, 1, 0, 3, 3, 64'h8123_4567_89AB_CDEF, 0, 0));
        tbl.push_back(mk(K_STORE, 3'd0, 64'h2000, 64'h1122_3344_5566_7788, 8'hFF, 0, 0, 5'd8, 1, 0, 4, 0, 0, 64'h1122_3344_5566_7788, 8'hFF));
        tbl.push_back(mk(K_STORE, 3'd1, 64'h2004, 64'h0000_0000_DEAD_BEEF, 8'h0F, 0, 0, 5'd9, 1, 1, 1, 0, 0, 64'hDEAD_BEEF_0000_0000, 8'hF0));
        tbl.push_back(mk(K_STORE, 3'd0, 64'h2003, 64'h0000_0000_0000_00AB, 8'h01, 0, 0, 5'd10, 1, 0, 0, 0, 0, 64'h0000_0000_AB00_0000, 8'h08));
        tbl.push_back(mk(K_PASS, 3'd0, 64'h0, 0, 0, 0, 64'h5, 5'd11, 1, 0, 0, 0, 64'h5, 0, 0));
        tbl.push_back(mk(K_PASS, 3'd0, 64'h0, 0, 0, 0, 64'hFFFF_0000_1234_5678, 5'd31, 0, 0, 0, 0, 64'hFFFF_0000_1234_5678, 0, 0));
        tbl.push_back(mk(K_EXC, 3'd1, 64'h3001, 0, 0, 0, 0, 5'd12, 1, 0, 0, 0, 0, 0, 0));

        rst = 1'b1;
        clear_ex();
        dmem_if.dmem_ready  = 1'b0;
        dmem_if.dmem_rvalid = 1'b0;
        dmem_if.dmem_rdata  = 64'd0;
        tick();
        tick();
        chk("rst.wb_valid", wb_valid, 0);
        chk("rst.wb_data", wb_data, 0);
        chk("rst.wb_rd", wb_rd_addr, 0);
        chk("rst.wb_wr_en", wb_wr_en, 0);
        chk("rst.wb_except", wb_except, 0);
        chk("rst.bus_err", bus_err, 0);
        chk("rst.req", dmem_if.dmem_req, 0);
        chk("rst.addr", dmem_if.dmem_addr, 0);
        chk("rst.wdata", dmem_if.dmem_wdata, 0);
        chk("rst.strb", dmem_if.dmem_strb, 0);
        chk("rst.we", dmem_if.dmem_we, 0);
        chk("rst.stall", stall_req, 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

        // Reset while waiting for a read response; a late rvalid is dropped.
        ex_valid = 1'b1; mem_rd_en = 1'b1; addr_mem_rd = 64'h4000; load_code = 3'd4;
        rd_addr = 5'd13; rd_wr_en = 1'b1;
        tick();
        clear_ex();
        dmem_if.dmem_ready = 1'b1;
        tick();
        dmem_if.dmem_ready = 1'b0;
        chk("rstresp.in_resp", stall_req, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstresp.idle", stall_req, 0);
        chk("rstresp.no_wb", wb_valid, 0);
        chk("rstresp.no_req", dmem_if.dmem_req, 0);
        dmem_if.dmem_rvalid = 1'b1;
        dmem_if.dmem_rdata  = 64'h1234;
        tick();
        dmem_if.dmem_rvalid = 1'b0;
        chk("rstresp.late_rvalid", wb_valid, 0);
        chk("rstresp.stall", stall_req, 0);
        tick();
        chk("rstresp.late_rvalid2", wb_valid, 0);
        apply(tbl[10], "after_rst");

        // Store with dmem_ready never given.
        ex_valid = 1'b1; mem_wr_en = 1'b1; addr_mem_wr = 64'h3000; data_mem_wr = 64'h77;
        strb_mem_wr = 8'h01; rd_addr = 5'd14;
        tick();
        clear_ex();
`ifdef MEM_TIMEOUT_EN
        hit = -1;
        for (int k = 0; k < 300; k++) begin
            if (bus_err) begin
                hit = k;
                break;
            end
            tick();
        end
        chk("tmo.cycles", hit, 255);
        chk("tmo.wb_valid", wb_valid, 1);
        chk("tmo.wb_except", wb_except, 1);
        chk("tmo.wb_wr_en", wb_wr_en, 0);
        chk("tmo.req_drop", dmem_if.dmem_req, 0);
        tick();
        chk("tmo.bus_err_pulse", bus_err, 0);
        chk("tmo.wb_pulse", wb_valid, 0);
`else
        nbe = 0;
        for (int k = 0; k < 300; k++) begin
            if (bus_err) nbe++;
            tick();
        end
        chk("notmo.bus_err", nbe, 0);
        chk("notmo.still_req", dmem_if.dmem_req, 1);
        chk("notmo.still_stall", stall_req, 1);
        dmem_if.dmem_ready = 1'b1;
        tick();
        dmem_if.dmem_ready = 1'b0;
        chk("notmo.wb_valid", wb_valid, 1);
        chk("notmo.wb_wr_en", wb_wr_en, 0);
        tick();
`endif

        // Randomized transactions against the reference model.
        for (int n = 0; n < 40; n++) begin
            v.kind    = int'($urandom_range(0, 3));
            v.code    = 3'($urandom_range(1, 7));
            v.addr    = {$urandom, $urandom};
            v.wdata   = {$urandom, $urandom};
            v.strb    = 8'($urandom);
            v.rdata   = {$urandom, $urandom};
            v.alu     = {$urandom, $urandom};
            v.rd      = 5'($urandom);
            v.wen     = 1'($urandom);
            v.both    = 1'($urandom);
            v.rdy_dly = int'($urandom_range(0, 3));
            v.rv_dly  = int'($urandom_range(0, 3));
            off       = int'(v.addr[2:0]);
            v.exp_wdata = model_wdata(v.wdata, off);
            v.exp_strb  = model_strb(v.strb, off);
            v.exp_data  = (v.kind == K_LOAD) ? model_load(v.code, off, v.rdata) : v.alu;
            apply(v, $sformatf("rnd%0d", n));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
